dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared data memory port.
- Port 0 is the core load/store path (memory stage). Port 1 is a secondary master (debug/DMA).
- Accepts one transaction at a time, drives the memory's active-low chip-select/write interface, waits for the memory's valid, and returns completion plus load data to the winning requester.
- Round-robin fairness when both request.

Parameters:
- AW, 32, address width
- DW, 32, data width; byte mask width is DW/8
- TIMEOUT, 64, BUSY-cycle limit before abort (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req, p1_req  in  1  request; held with fields stable until gnt
- p0_we, p1_we  in  1  1 = store, 0 = load
- p0_addr, p1_addr  in  AW  byte address
- p0_wdata, p1_wdata  in  DW  store data, already lane-aligned
- p0_mask, p1_mask  in  DW/8  byte enables
- p0_gnt, p1_gnt  out  1  combinational accept pulse
- p0_rvalid, p1_rvalid  out  1  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DW  load data, valid with rvalid
- mem_cs  out  1  chip select, active-low
- mem_wr  out  1  0 = write, 1 = read
- mem_addr  out  AW
- mem_wdata  out  DW
- mem_mask  out  DW/8
- mem_rdata  in  DW
- mem_valid  in  1  memory response strobe
- err  out  1  timeout pulse; tied 0 when the optional feature is absent

Behaviour:
- Reset values:
  - FSM IDLE, mem_cs=1, mem_wr=1.
  - mem_addr, mem_wdata, mem_mask = 0.
  - All gnt, rvalid, rdata, err = 0.
  - last_grant=1, so port 0 has priority first.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req, grant combinationally in the same cycle.
  - Only one requester: it wins.
  - Both requesting: the port not equal to last_grant wins.
  - On the grant edge: latch we/addr/wdata/mask into the memory registers, record the owner, update last_grant, go to BUSY.
- BUSY:
  - mem_cs=0; mem_wr = ~we; address, data and mask held stable.
  - All gnt=0; new requests wait.
  - On the edge where mem_valid=1: owner rdata <= mem_rdata for loads (rdata unchanged for stores); owner rvalid=1 for the following cycle; return to IDLE with mem_cs=1.
- Timing, with the grant in cycle T and mem_valid first high in cycle T+k (k>=1):
  - mem_cs low in cycles T+1..T+k.
  - rvalid high in cycle T+k+1.
  - A new grant is possible in cycle T+k+1. Minimum occupancy is 2 cycles.
- mem_valid while IDLE is ignored.
- rvalid pulses for both loads and stores; it is never high for the non-owner.
- rdata holds its last value until the next load completion on that port.
- A requester dropping req before gnt is legal; nothing is issued for it.
- Simultaneous req on both ports in IDLE: exactly one gnt; the loser is granted at the next IDLE, provided it still holds req.
- mask is passed through unmodified. Loads may carry any mask; the memory ignores it on reads.
- Reset mid-transaction aborts immediately: outputs go to reset values, no rvalid is issued, last_grant=1.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on grant and increments each BUSY cycle.
  - If it reaches TIMEOUT with no mem_valid: return to IDLE, pulse owner rvalid with rdata=0, pulse err for 1 cycle together with that rvalid.
  - mem_valid arriving in the same cycle as the limit counts as a normal completion, with no err.
- Not defined: no counter, err tied 0, BUSY waits indefinitely.

Test Plan:
- Single load, port 0:
  - Stimulus: p0 load, addr=0x100, mem_valid 3 cycles after grant, mem_rdata=0xDEADBEEF.
  - Response: p0_gnt in cycle T; mem_cs=0, mem_wr=1 in T+1..T+3; p0_rvalid with p0_rdata=0xDEADBEEF in T+4; p1 sees nothing.
- Store, port 1:
  - Stimulus: p1 store, addr=0x204, wdata=0x0000AB00, mask=4'b0010, mem_valid 1 cycle later.
  - Response: mem_wr=0 with addr/data/mask matching; p1_rvalid in T+2; p1_rdata unchanged.
- Contention:
  - Stimulus: both ports request continuously for 4 transactions, memory latency 1.
  - Response: grants in order p0, p1, p0, p1, each with its own rvalid.
- Reset mid-transaction:
  - Stimulus: assert rst in BUSY, 2 cycles after a p0 grant.
  - Response: mem_cs=1 immediately (asynchronous), no p0_rvalid; after release, a p1 request is granted normally.
- Timeout (DMEM_ARB_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: p0 load with mem_valid never asserted.
  - Response: p0_rvalid=1, p0_rdata=0 and err=1 for one cycle after 8 BUSY cycles; FSM back in IDLE.
- Spurious strobe:
  - Stimulus: mem_valid pulsed in IDLE.
  - Response: no rvalid, no state change.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter/sequencer for the shared data memory port.
// Latency: grant is combinational in IDLE; rvalid one cycle after mem_valid; 2 cycles minimum per transaction.
// Backpressure: gnt held low while a transaction is outstanding; the memory stalls us by withholding mem_valid.
// Optional: define DMEM_ARB_TIMEOUT_EN to abort after TIMEOUT BUSY cycles with an err pulse.
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    input  logic [DW/8-1:0] p0_mask,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    output logic [DW-1:0]   p0_rdata,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    input  logic [DW/8-1:0] p1_mask,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    output logic [DW-1:0]   p1_rdata,
    output logic            mem_cs,
    output logic            mem_wr,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_valid,
    output logic            err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;
    logic   last_grant;   // 1 = port 1 won last, so port 0 wins the next tie
    logic   owner;        // port that owns the outstanding transaction
    logic   done;         // memory answered this cycle
    logic   timeout;      // BUSY limit hit without an answer
    logic   finish;

    assign done   = (state == BUSY) && mem_valid;
    assign finish = done || timeout;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and combinational grant; ties go to the port that did not win last
    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    p0_gnt = last_grant;
                    p1_gnt = ~last_grant;
                end else begin
                    p0_gnt = p0_req;
                    p1_gnt = p1_req;
                end
                if (p0_req || p1_req) state_nxt = BUSY;
            end
            BUSY: begin
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side registers: capture the winner's fields at grant, release chip-select at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cs     <= 1'b1;
            mem_wr     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (p0_gnt || p1_gnt) begin
            mem_cs     <= 1'b0;
            mem_wr     <= p1_gnt ? ~p1_we    : ~p0_we;
            mem_addr   <= p1_gnt ? p1_addr   : p0_addr;
            mem_wdata  <= p1_gnt ? p1_wdata  : p0_wdata;
            mem_mask   <= p1_gnt ? p1_mask   : p0_mask;
            owner      <= p1_gnt;
            last_grant <= p1_gnt;
        end else if (finish) begin
            mem_cs     <= 1'b1;
            mem_wr     <= 1'b1;
        end
    end

    // Requester-side response: rvalid pulse to the owner; load data captured, stores leave rdata alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= finish && !owner;
            p1_rvalid <= finish && owner;
            if (timeout) begin
                if (owner) p1_rdata <= '0;
                else       p0_rdata <= '0;
            end else if (done && mem_wr) begin
                if (owner) p1_rdata <= mem_rdata;
                else       p0_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;

    // to_cnt holds the number of completed BUSY cycles, so the limit fires on the TIMEOUT-th one
    assign timeout = (state == BUSY) && !mem_valid && (to_cnt == CW'(TIMEOUT - 1));

    // BUSY-cycle counter, restarted by every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   to_cnt <= '0;
        else if (p0_gnt || p1_gnt) to_cnt <= '0;
        else if (state == BUSY)    to_cnt <= to_cnt + 1'b1;
    end

    // err rides alongside the aborting rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= timeout;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [3:0]  p0_mask = 0, p1_mask = 0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_cs, mem_wr, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata = 0;
    logic        mem_valid = 0;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mask(p0_mask),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mask(p1_mask),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction, round-robin on ties, response one cycle after the strobe
    bit          m_busy;
    int          m_own, m_last, m_bcnt, win;
    bit          m_we, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    bit          m_rv [2];
    logic [31:0] m_rd [2];

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_last = 1; m_own = 0; m_bcnt = 0; m_err = 0;
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        end else begin
            win = -1;
            if (!m_busy) begin
                if (p0_req && p1_req) win = (m_last == 1) ? 0 : 1;
                else if (p0_req)      win = 0;
                else if (p1_req)      win = 1;
            end
            chk("m_gnt0", p0_gnt, win == 0);
            chk("m_gnt1", p1_gnt, win == 1);
            chk("m_rvalid0", p0_rvalid, m_rv[0]);
            chk("m_rvalid1", p1_rvalid, m_rv[1]);
            chk("m_rdata0", p0_rdata, m_rd[0]);
            chk("m_rdata1", p1_rdata, m_rd[1]);
            chk("m_err", err, m_err);
            chk("m_cs", mem_cs, !m_busy);
            if (m_busy) begin
                chk("m_wr", mem_wr, !m_we);
                chk("m_addr", mem_addr, m_addr);
                chk("m_wdata", mem_wdata, m_wdata);
                chk("m_mask", mem_mask, m_mask);
            end
            m_rv[0] = 0; m_rv[1] = 0; m_err = 0;
            if (m_busy) begin
                m_bcnt++;
                if (mem_valid) begin
                    m_rv[m_own] = 1;
                    if (!m_we) m_rd[m_own] = mem_rdata;
                    m_busy = 0;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (m_bcnt == 8) begin
                    m_rv[m_own] = 1;
                    m_rd[m_own] = 0;
                    m_err = 1;
                    m_busy = 0;
                end
`endif
            end else if (win >= 0) begin
                m_busy  = 1;
                m_bcnt  = 0;
                m_own   = win;
                m_last  = win;
                m_we    = (win == 1) ? p1_we    : p0_we;
                m_addr  = (win == 1) ? p1_addr  : p0_addr;
                m_wdata = (win == 1) ? p1_wdata : p0_wdata;
                m_mask  = (win == 1) ? p1_mask  : p0_mask;
            end
        end
    end

    int gseq[$];

    initial begin
        // reset state
        #1 rst = 1;
        #6;
        chk("rst_cs", mem_cs, 1);
        chk("rst_wr", mem_wr, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_mask", mem_mask, 0);
        chk("rst_rvalid0", p0_rvalid, 0);
        chk("rst_rdata1", p1_rdata, 0);
        chk("rst_err", err, 0);
        tick(); rst = 0;
        tick();

        // single load on port 0, memory answers 3 cycles after the grant
        tick(); p0_req = 1; p0_we = 0; p0_addr = 32'h100; p0_mask = 4'hF;
        #2 chk("t1_gnt0", p0_gnt, 1);
        tick(); p0_req = 0;
        #2 chk("t1_cs_t1", mem_cs, 0); chk("t1_wr_t1", mem_wr, 1); chk("t1_addr", mem_addr, 32'h100);
        tick(); #2 chk("t1_cs_t2", mem_cs, 0);
        tick(); mem_valid = 1; mem_rdata = 32'hDEADBEEF;
        #2 chk("t1_cs_t3", mem_cs, 0);
        tick(); mem_valid = 0;
        #2 chk("t1_rvalid0", p0_rvalid, 1); chk("t1_rdata0", p0_rdata, 32'hDEADBEEF);
        chk("t1_rvalid1", p1_rvalid, 0); chk("t1_cs_t4", mem_cs, 1);

        // store on port 1, latency 1; port 0 raises and drops req while BUSY
        tick(); p1_req = 1; p1_we = 1; p1_addr = 32'h204; p1_wdata = 32'h0000AB00; p1_mask = 4'b0010;
        #2 chk("t2_gnt1", p1_gnt, 1);
        tick(); p1_req = 0; mem_valid = 1; p0_req = 1; p0_addr = 32'h300;
        #2 chk("t2_wr", mem_wr, 0); chk("t2_addr", mem_addr, 32'h204);
        chk("t2_wdata", mem_wdata, 32'h0000AB00); chk("t2_mask", mem_mask, 4'b0010);
        chk("t2_gnt0_busy", p0_gnt, 0);
        tick(); mem_valid = 0; p0_req = 0;
        #2 chk("t2_rvalid1", p1_rvalid, 1); chk("t2_rdata1", p1_rdata, 0); chk("t2_nogrant", p0_gnt, 0);

        // contention: both ports request continuously, memory latency 1
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                p0_req = 1; p0_we = 0; p0_addr = 32'h400;
                p1_req = 1; p1_we = 0; p1_addr = 32'h800;
                mem_valid = 1;
            end
            mem_rdata = 32'h1000 + i;
            #2;
            if (p0_gnt) gseq.push_back(0);
            if (p1_gnt) gseq.push_back(1);
        end
        tick(); p0_req = 0; p1_req = 0;
        tick(); mem_valid = 0;
        chk("t3_ngrants", gseq.size(), 4);
        for (int k = 0; k < gseq.size(); k++) chk("t3_order", gseq[k], k % 2);
        chk("t3_rdata1", p1_rdata, 32'h1006);

        // reset two cycles into a port 0 transaction
        tick(); p0_req = 1; p0_we = 0; p0_addr = 32'h500;
        #2 chk("t4_gnt0", p0_gnt, 1);
        tick(); p0_req = 0;
        tick(); #2 rst = 1;
        #1 chk("t4_cs_async", mem_cs, 1); chk("t4_addr_rst", mem_addr, 0);
        tick(); rst = 0;
        #2 chk("t4_no_rvalid0", p0_rvalid, 0);
        tick(); p1_req = 1; p1_we = 0; p1_addr = 32'h600;
        #2 chk("t4_gnt1", p1_gnt, 1); chk("t4_gnt0", p0_gnt, 0);
        tick(); p1_req = 0; mem_valid = 1; mem_rdata = 32'h12345678;
        tick(); mem_valid = 0;
        #2 chk("t4_rvalid1", p1_rvalid, 1); chk("t4_rdata1", p1_rdata, 32'h12345678);

        // spurious strobe in IDLE, then a normal port 0 load
        tick(); mem_valid = 1; mem_rdata = 32'h55;
        tick(); mem_valid = 0;
        #2 chk("t5_rvalid0", p0_rvalid, 0); chk("t5_rvalid1", p1_rvalid, 0); chk("t5_cs", mem_cs, 1);
        tick(); p0_req = 1; p0_we = 0; p0_addr = 32'h700; p0_mask = 4'b0001;
        #2 chk("t5_gnt0", p0_gnt, 1);
        tick(); p0_req = 0; mem_valid = 1; mem_rdata = 32'hA5A50001;
        #2 chk("t5_mask", mem_mask, 4'b0001);
        tick(); mem_valid = 0;
        #2 chk("t5_rdata0", p0_rdata, 32'hA5A50001);

`ifdef DMEM_ARB_TIMEOUT_EN
        // timeout: memory never answers, abort after 8 BUSY cycles
        tick(); p0_req = 1; p0_we = 0; p0_addr = 32'h900;
        #2 chk("t6_gnt0", p0_gnt, 1);
        tick(); p0_req = 0;
        repeat (7) tick();
        #2 chk("t6_cs_last", mem_cs, 0); chk("t6_err_early", err, 0);
        tick();
        #2 chk("t6_rvalid0", p0_rvalid, 1); chk("t6_rdata0", p0_rdata, 0); chk("t6_err", err, 1);
        tick();
        #2 chk("t6_err_clr", err, 0); chk("t6_cs_idle", mem_cs, 1);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
